// File: rtl/nn_bus_pkg.sv
// Shared definitions for the PE array bus: default widths, broadcast tag value
// and the {tag, payload} packet layout carried between bus levels.
package nn_bus_pkg;

    localparam int NN_ADDRESS_WIDTH = 4;
    localparam int NN_BITWIDTH      = 20;

    localparam logic [NN_ADDRESS_WIDTH-1:0] NN_WILDCARD_TAG = {NN_ADDRESS_WIDTH{1'b1}};

    // Tag occupies the upper bits so a packet can be split with a plain concatenation.
    typedef struct packed {
        logic [NN_ADDRESS_WIDTH-1:0] tag;
        logic [NN_BITWIDTH-1:0]      payload;
    } nn_packet_t;

endpackage

// File: rtl/mc_fifo.sv
// Small synchronous FIFO holding {tag, payload} packets for the multicast controller.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module mc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/multicast_fanout_controller.sv
// Multicast fan-out from one bus input to NUM_TARGETS scan-programmed targets.
// Define MC_WILDCARD_EN to make an all-ones head tag broadcast to every target.
module multicast_fanout_controller
    import nn_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH = NN_ADDRESS_WIDTH,
    parameter int BITWIDTH      = NN_BITWIDTH,
    parameter int NUM_TARGETS   = 4,
    parameter int FIFO_DEPTH    = 2,
    parameter int MISS_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     program_en,
    input  logic [ADDRESS_WIDTH-1:0] scan_tag_in,
    output logic [ADDRESS_WIDTH-1:0] scan_tag_out,
    input  logic                     controller_enable,
    output logic                     controller_ready,
    input  logic [ADDRESS_WIDTH-1:0] tag,
    input  logic [BITWIDTH-1:0]      input_value,
    output logic [NUM_TARGETS-1:0]   target_enable,
    input  logic [NUM_TARGETS-1:0]   target_ready,
    output logic [BITWIDTH-1:0]      output_value,
    output logic [MISS_WIDTH-1:0]    miss_count
);

    localparam int PKT_WIDTH = ADDRESS_WIDTH + BITWIDTH;
    localparam logic [MISS_WIDTH-1:0] MISS_ONE = {{(MISS_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDRESS_WIDTH-1:0] tag_id_q [NUM_TARGETS];
    logic [ADDRESS_WIDTH-1:0] tag_id_d [NUM_TARGETS];
    logic [NUM_TARGETS-1:0]   served_q, served_d;
    logic [MISS_WIDTH-1:0]    miss_q, miss_d;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     head_valid;
    logic [PKT_WIDTH-1:0]     head_pkt;
    logic [ADDRESS_WIDTH-1:0] head_tag;
    logic [BITWIDTH-1:0]      head_payload;
    logic                     wildcard_hit;
    logic [NUM_TARGETS-1:0]   match;
    logic [NUM_TARGETS-1:0]   pending;

    mc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PKT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (push),
        .pop   (pop),
        .wdata ({tag, input_value}),
        .rdata (head_pkt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready looks only at this cycle's full flag; a same-cycle pop frees the slot next cycle.
    assign controller_ready = rstb & ~fifo_full & ~program_en;
    assign push             = controller_enable & controller_ready;

    // Programming freezes dispatch so the FIFO and served vector hold their state.
    assign head_valid                 = ~fifo_empty & ~program_en;
    assign {head_tag, head_payload}   = head_pkt;

`ifdef MC_WILDCARD_EN
    localparam logic [ADDRESS_WIDTH-1:0] WILDCARD_TAG = {ADDRESS_WIDTH{1'b1}};
    assign wildcard_hit = (head_tag == WILDCARD_TAG);
`else
    assign wildcard_hit = 1'b0;
`endif

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            match[i] = head_valid & (wildcard_hit | (head_tag == tag_id_q[i]));
        end
    end

    // The head retires once no matching target is still waiting to accept it.
    assign target_enable = match & ~served_q;
    assign pending       = target_enable & ~target_ready;
    assign pop           = head_valid & (pending == '0);

    assign output_value = head_valid ? head_payload : '0;
    assign scan_tag_out = tag_id_q[NUM_TARGETS-1];
    assign miss_count   = miss_q;

    always_comb begin
        tag_id_d = tag_id_q;
        if (program_en) begin
            tag_id_d[0] = scan_tag_in;
            for (int i = 1; i < NUM_TARGETS; i++) begin
                tag_id_d[i] = tag_id_q[i-1];
            end
        end
    end

    always_comb begin
        served_d = served_q;
        if (pop) begin
            served_d = '0;
        end else begin
            served_d = served_q | (target_enable & target_ready);
        end
    end

    always_comb begin
        miss_d = miss_q;
        if (pop && (match == '0) && (miss_q != {MISS_WIDTH{1'b1}})) begin
            miss_d = miss_q + MISS_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            served_q <= '0;
            miss_q   <= '0;
            for (int i = 0; i < NUM_TARGETS; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            served_q <= served_d;
            miss_q   <= miss_d;
            tag_id_q <= tag_id_d;
        end
    end

endmodule

// File: tb/tb_multicast_fanout_controller.sv
// Directed bench for multicast_fanout_controller: vector table for scan, unicast,
// staggered multicast and miss, then sequences for saturation, backpressure and reset.
module tb_multicast_fanout_controller;

    logic        clk;
    logic        rstb;
    logic        program_en;
    logic [3:0]  scan_tag_in;
    logic [3:0]  scan_tag_out;
    logic        controller_enable;
    logic        controller_ready;
    logic [3:0]  tag;
    logic [19:0] input_value;
    logic [3:0]  target_enable;
    logic [3:0]  target_ready;
    logic [19:0] output_value;
    logic [7:0]  miss_count;

    int checks   = 0;
    int failures = 0;

    multicast_fanout_controller #(
        .ADDRESS_WIDTH (4),
        .BITWIDTH      (20),
        .NUM_TARGETS   (4),
        .FIFO_DEPTH    (2),
        .MISS_WIDTH    (8)
    ) dut (
        .clk               (clk),
        .rstb              (rstb),
        .program_en        (program_en),
        .scan_tag_in       (scan_tag_in),
        .scan_tag_out      (scan_tag_out),
        .controller_enable (controller_enable),
        .controller_ready  (controller_ready),
        .tag               (tag),
        .input_value       (input_value),
        .target_enable     (target_enable),
        .target_ready      (target_ready),
        .output_value      (output_value),
        .miss_count        (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        prog;
        logic [3:0]  scan;
        logic        cen;
        logic [3:0]  tg;
        logic [19:0] val;
        logic [3:0]  trdy;
        logic [3:0]  exp_en;
        logic        exp_rdy;
        logic [19:0] exp_out;
        logic [7:0]  exp_miss;
        logic [3:0]  exp_sout;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tagname, input logic [3:0] en, input logic rdy,
                             input logic [19:0] outv, input logic [7:0] miss, input logic [3:0] sout);
        chk({tagname, ".target_enable"}, {28'd0, target_enable}, {28'd0, en});
        chk({tagname, ".controller_ready"}, {31'd0, controller_ready}, {31'd0, rdy});
        chk({tagname, ".output_value"}, {12'd0, output_value}, {12'd0, outv});
        chk({tagname, ".miss_count"}, {24'd0, miss_count}, {24'd0, miss});
        chk({tagname, ".scan_tag_out"}, {28'd0, scan_tag_out}, {28'd0, sout});
    endtask

    task automatic drive(input logic prog, input logic [3:0] scan, input logic cen,
                         input logic [3:0] tg, input logic [19:0] val, input logic [3:0] trdy);
        program_en        = prog;
        scan_tag_in       = scan;
        controller_enable = cen;
        tag               = tg;
        input_value       = val;
        target_ready      = trdy;
    endtask

    initial begin
        int accepted;
        logic [3:0] wc_en;
        logic [7:0] wc_miss;

        //           prog  scan   cen   tag    val      trdy  | en     rdy   out      miss   sout
        vt[0]  = '{1'b1, 4'd0, 1'b0, 4'd0, 20'd0,   4'h0, 4'h0, 1'b0, 20'd0,   8'd0, 4'd0};
        vt[1]  = '{1'b1, 4'd1, 1'b0, 4'd0, 20'd0,   4'h0, 4'h0, 1'b0, 20'd0,   8'd0, 4'd0};
        vt[2]  = '{1'b1, 4'd2, 1'b0, 4'd0, 20'd0,   4'h0, 4'h0, 1'b0, 20'd0,   8'd0, 4'd0};
        vt[3]  = '{1'b1, 4'd3, 1'b1, 4'd2, 20'd512, 4'hF, 4'h0, 1'b0, 20'd0,   8'd0, 4'd0};
        vt[4]  = '{1'b0, 4'd0, 1'b1, 4'd2, 20'd512, 4'hF, 4'h0, 1'b1, 20'd0,   8'd0, 4'd0};
        vt[5]  = '{1'b0, 4'd0, 1'b0, 4'd0, 20'd0,   4'hF, 4'h2, 1'b1, 20'd512, 8'd0, 4'd0};
        vt[6]  = '{1'b0, 4'd0, 1'b0, 4'd0, 20'd0,   4'hF, 4'h0, 1'b1, 20'd0,   8'd0, 4'd0};
        vt[7]  = '{1'b1, 4'd1, 1'b0, 4'd0, 20'd0,   4'h0, 4'h0, 1'b0, 20'd0,   8'd0, 4'd0};
        vt[8]  = '{1'b1, 4'd1, 1'b0, 4'd0, 20'd0,   4'h0, 4'h0, 1'b0, 20'd0,   8'd0, 4'd1};
        vt[9]  = '{1'b1, 4'd5, 1'b0, 4'd0, 20'd0,   4'h0, 4'h0, 1'b0, 20'd0,   8'd0, 4'd2};
        vt[10] = '{1'b1, 4'd1, 1'b0, 4'd0, 20'd0,   4'h0, 4'h0, 1'b0, 20'd0,   8'd0, 4'd3};
        vt[11] = '{1'b0, 4'd0, 1'b1, 4'd1, 20'd257, 4'h0, 4'h0, 1'b1, 20'd0,   8'd0, 4'd1};
        vt[12] = '{1'b0, 4'd0, 1'b0, 4'd0, 20'd0,   4'h1, 4'hD, 1'b1, 20'd257, 8'd0, 4'd1};
        vt[13] = '{1'b0, 4'd0, 1'b0, 4'd0, 20'd0,   4'h4, 4'hC, 1'b1, 20'd257, 8'd0, 4'd1};
        vt[14] = '{1'b0, 4'd0, 1'b0, 4'd0, 20'd0,   4'h8, 4'h8, 1'b1, 20'd257, 8'd0, 4'd1};
        vt[15] = '{1'b0, 4'd0, 1'b0, 4'd0, 20'd0,   4'h0, 4'h0, 1'b1, 20'd0,   8'd0, 4'd1};
        vt[16] = '{1'b0, 4'd0, 1'b1, 4'd9, 20'd7,   4'h0, 4'h0, 1'b1, 20'd0,   8'd0, 4'd1};
        vt[17] = '{1'b0, 4'd0, 1'b0, 4'd0, 20'd0,   4'h0, 4'h0, 1'b1, 20'd7,   8'd0, 4'd1};
        vt[18] = '{1'b0, 4'd0, 1'b0, 4'd0, 20'd0,   4'h0, 4'h0, 1'b1, 20'd0,   8'd1, 4'd1};

        rstb = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 4'd0, 20'd0, 4'h0);
        #2;
        check_all("reset", 4'h0, 1'b0, 20'd0, 8'd0, 4'd0);
        next_cycle();
        next_cycle();
        rstb = 1'b1;

        for (int r = 0; r < 19; r++) begin
            drive(vt[r].prog, vt[r].scan, vt[r].cen, vt[r].tg, vt[r].val, vt[r].trdy);
            #1;
            check_all($sformatf("vec%0d", r), vt[r].exp_en, vt[r].exp_rdy, vt[r].exp_out,
                      vt[r].exp_miss, vt[r].exp_sout);
            next_cycle();
        end

        // Miss counter saturation: 255 further misses on top of the one already counted.
        accepted = 0;
        for (int i = 0; i < 255; i++) begin
            drive(1'b0, 4'd0, 1'b1, 4'd9, 20'(i), 4'h0);
            #1;
            if (controller_ready) accepted++;
            if (i == 100) chk("miss_mid", {24'd0, miss_count}, 32'd100);
            next_cycle();
        end
        drive(1'b0, 4'd0, 1'b0, 4'd0, 20'd0, 4'h0);
        next_cycle();
        next_cycle();
        chk("miss_accepted", accepted, 32'd255);
        chk("miss_saturated", {24'd0, miss_count}, 32'd255);

        // Backpressure: IDs are {1,5,1,1}, tag 5 goes to target 1 only.
        drive(1'b0, 4'd0, 1'b1, 4'd5, 20'd100, 4'h0);
        #1;
        chk("bp_ready0", {31'd0, controller_ready}, 32'd1);
        next_cycle();
        drive(1'b0, 4'd0, 1'b1, 4'd5, 20'd101, 4'h0);
        #1;
        chk("bp_ready1", {31'd0, controller_ready}, 32'd1);
        chk("bp_en_stall", {28'd0, target_enable}, 32'h2);
        next_cycle();
        drive(1'b0, 4'd0, 1'b1, 4'd5, 20'd102, 4'h0);
        #1;
        chk("bp_ready_full", {31'd0, controller_ready}, 32'd0);
        chk("bp_head_hold", {12'd0, output_value}, 32'd100);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 20'd0, 4'h2);
        #1;
        check_all("bp_first", 4'h2, 1'b0, 20'd100, 8'd255, 4'd1);
        next_cycle();
        #1;
        check_all("bp_second", 4'h2, 1'b1, 20'd101, 8'd255, 4'd1);
        next_cycle();
        #1;
        check_all("bp_drained", 4'h0, 1'b1, 20'd0, 8'd255, 4'd1);

        // Reset in the middle of a partially served multicast.
        drive(1'b0, 4'd0, 1'b1, 4'd1, 20'd33, 4'h0);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 20'd0, 4'h1);
        #1;
        chk("rst_pre_en", {28'd0, target_enable}, 32'hD);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 20'd0, 4'h0);
        #1;
        chk("rst_served_en", {28'd0, target_enable}, 32'hC);
        rstb = 1'b0;
        #1;
        check_all("rst_mid", 4'h0, 1'b0, 20'd0, 8'd0, 4'd0);
        next_cycle();
        rstb = 1'b1;
        #1;
        check_all("rst_after", 4'h0, 1'b1, 20'd0, 8'd0, 4'd0);

        // IDs were cleared, so tag 0 now reaches all four targets.
        drive(1'b0, 4'd0, 1'b1, 4'd0, 20'd44, 4'hF);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 20'd0, 4'hF);
        #1;
        check_all("ids_cleared", 4'hF, 1'b1, 20'd44, 8'd0, 4'd0);
        next_cycle();

`ifdef MC_WILDCARD_EN
        wc_en   = 4'hF;
        wc_miss = 8'd0;
`else
        wc_en   = 4'h0;
        wc_miss = 8'd1;
`endif
        drive(1'b0, 4'd0, 1'b1, 4'd15, 20'd55, 4'hF);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 20'd0, 4'hF);
        #1;
        chk("wildcard_en", {28'd0, target_enable}, {28'd0, wc_en});
        chk("wildcard_out", {12'd0, output_value}, 32'd55);
        next_cycle();
        #1;
        chk("wildcard_miss", {24'd0, miss_count}, {24'd0, wc_miss});
        chk("wildcard_retired", {28'd0, target_enable}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
